// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer.
//   fetch_state_e : controller state encoding (BOOT, RUN, DRAIN, HALTED)
//   redir_src_e   : winning redirect source this cycle, kept for debug visibility
//   INSN_BYTES    : default sequential PC increment
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StDrain,
    StHalted
  } fetch_state_e;

  typedef enum logic [1:0] {
    RedirNone,
    RedirTrap,
    RedirEx,
    RedirReplay
  } redir_src_e;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Outstanding-request and stale-response bookkeeping for the imem port.
//   clk, reset : clock, synchronous active-high reset
//   req_fire   : request accepted by imem this cycle
//   rsp_valid  : in-order response returned this cycle
//   redirect   : redirect or replay this cycle; everything in flight becomes stale
//   can_issue  : another request may be issued (outstanding < MAX_OUTST)
//   rsp_stale  : the response at the head of the stream must be discarded
//   idle       : nothing outstanding
module fetch_inflight_tracker #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_fire,
  input  logic rsp_valid,
  input  logic redirect,
  output logic can_issue,
  output logic rsp_stale,
  output logic idle
);

  localparam logic [CNT_W-1:0] MaxOutst = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             rsp_counted;

  // A response with nothing outstanding is a protocol error; counters stay at 0.
  assign rsp_counted = rsp_valid && (outst_cnt_q != '0);

  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (req_fire && !rsp_counted) begin
      outst_cnt_d = outst_cnt_q + 1'b1;
    end else if (!req_fire && rsp_counted) begin
      outst_cnt_d = outst_cnt_q - 1'b1;
    end

    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      // The response arriving alongside the redirect is itself discarded.
      drop_cnt_d = rsp_counted ? outst_cnt_q - 1'b1 : outst_cnt_q;
    end else if (rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      outst_cnt_q <= outst_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign can_issue = outst_cnt_q < MaxOutst;
  assign rsp_stale = drop_cnt_q != '0;
  assign idle      = outst_cnt_q == '0;

  rsp_no_underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(rsp_valid && (outst_cnt_q == '0)));

  outst_in_range_a: assert property (@(posedge clk) disable iff (reset)
    outst_cnt_q <= MaxOutst);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the fetch PC adder operands, halt and restore_pc,
// arbitrates redirects (trap > EX redirect > replay > sequential), issues imem
// requests, filters stale responses and squashes IF/ID and ID/EX.
//   clk, reset                  : clock, synchronous active-high reset
//   pc                          : current fetch PC
//   imem_req_ready/valid        : imem request handshake (address is pc)
//   imem_rsp_valid              : in-order instruction response
//   stall_id                    : decode hazard stall
//   ex_redirect_valid/target    : branch/jump resolved in EX
//   trap_valid/vector           : exception/interrupt entry
//   replay_req                  : re-fetch the previous PC
//   halt_req/resume_req         : debug halt (level) / resume (pulse)
//   fetch_halt/fetch_restore_pc : fetch stage controls
//   load_pc_A/B                 : PC adder operands
//   if_id_valid                 : accepted, non-stale response this cycle
//   flush_if_id/flush_id_ex     : pipeline squashes
//   halted                      : controller is in HALTED
module fetch_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned INSN_BYTES = fetch_ctrl_pkg::INSN_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             imem_req_ready,
  output logic             imem_req_valid,
  input  logic             imem_rsp_valid,
  input  logic             stall_id,
  input  logic             ex_redirect_valid,
  input  logic [WIDTH-1:0] ex_redirect_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             replay_req,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             fetch_halt,
  output logic             fetch_restore_pc,
  output logic [WIDTH-1:0] load_pc_A,
  output logic [WIDTH-1:0] load_pc_B,
  output logic             if_id_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted
);

  import fetch_ctrl_pkg::*;

  fetch_state_e state_q, state_d;
  redir_src_e   redir_src;
  logic         active, redirect, req_fire;
  logic         can_issue, rsp_stale, idle;

  assign active = (state_q == StRun) || (state_q == StDrain);

  always_comb begin
    redir_src = RedirNone;
    if (active) begin
      if (trap_valid)             redir_src = RedirTrap;
      else if (ex_redirect_valid) redir_src = RedirEx;
      else if (replay_req)        redir_src = RedirReplay;
    end
  end

  assign redirect       = !reset && (redir_src != RedirNone);
  assign imem_req_valid = !reset && (state_q == StRun) && !stall_id && can_issue && !redirect;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign if_id_valid    = !reset && imem_rsp_valid && !rsp_stale && !redirect;

  fetch_inflight_tracker #(
    .MAX_OUTST(MAX_OUTST),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .req_fire (req_fire),
    .rsp_valid(imem_rsp_valid),
    .redirect (redirect),
    .can_issue(can_issue),
    .rsp_stale(rsp_stale),
    .idle     (idle)
  );

  always_comb begin
    fetch_halt       = 1'b1;
    fetch_restore_pc = 1'b0;
    load_pc_A        = pc;
    load_pc_B        = '0;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    halted           = 1'b0;
    unique case (state_q)
      StBoot: begin
        // Nothing valid in the pipeline yet.
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      StRun, StDrain: begin
        unique case (redir_src)
          RedirTrap: begin
            fetch_halt  = 1'b0;
            load_pc_A   = trap_vector;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
          RedirEx: begin
            fetch_halt  = 1'b0;
            load_pc_A   = ex_redirect_target;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
          RedirReplay: begin
            fetch_halt       = 1'b0;
            fetch_restore_pc = 1'b1;
            flush_if_id      = 1'b1;
          end
          RedirNone: begin
            // Advance only when the request for the current PC is accepted.
            load_pc_B  = WIDTH'(INSN_BYTES);
            fetch_halt = !req_fire;
          end
        endcase
      end
      StHalted: begin
        halted = 1'b1;
      end
    endcase
    if (reset) begin
      fetch_halt       = 1'b1;
      fetch_restore_pc = 1'b0;
      load_pc_A        = '0;
      load_pc_B        = '0;
      flush_if_id      = 1'b1;
      flush_id_ex      = 1'b1;
      halted           = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (halt_req) state_d = StDrain;
      StDrain:  if (idle && !imem_rsp_valid) state_d = StHalted;
      StHalted: if (resume_req) state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StBoot;
    else       state_q <= state_d;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the fetch PC register and the instruction-memory request port. Every cycle it picks the PC adder operands (load_pc_A/B), halt and restore_pc for the fetch stage.
- Arbitrates redirect sources with fixed priority: trap > execute redirect > replay > sequential.
- Tracks outstanding imem requests and discards responses made stale by a redirect.
- Drives IF/ID and ID/EX flushes.

Parameters:
- WIDTH, 32, PC and address width.
- MAX_OUTST, 2, max in-flight imem requests (1..3).
- CNT_W, 2, width of outstanding/drop counters; must satisfy 2^CNT_W > MAX_OUTST.
- INSN_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  WIDTH  current fetch PC (fetch stage pc_out).
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_req_valid  out  1  request for address pc.
- imem_rsp_valid  in  1  instruction returned, in order.
- stall_id  in  1  decode hazard stall (load-use).
- ex_redirect_valid  in  1  taken branch/jump resolved in EX.
- ex_redirect_target  in  WIDTH  target address.
- trap_valid  in  1  exception/interrupt taken.
- trap_vector  in  WIDTH  handler address.
- replay_req  in  1  re-fetch previous PC.
- halt_req  in  1  debug/ebreak halt request (level).
- resume_req  in  1  leave HALTED (pulse).
- fetch_halt  out  1  to fetch halt.
- fetch_restore_pc  out  1  to fetch restore_pc.
- load_pc_A  out  WIDTH  adder operand A.
- load_pc_B  out  WIDTH  adder operand B.
- if_id_valid  out  1  accepted, non-stale response this cycle.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- halted  out  1  state == HALTED.

Behaviour:
- States: BOOT, RUN, DRAIN, HALTED. Registers: state, outst_cnt, drop_cnt.
- Reset: state=BOOT, outst_cnt=0, drop_cnt=0. During reset: fetch_halt=1, imem_req_valid=0, restore=0, A=B=0, flushes=1, if_id_valid=0, halted=0.
- BOOT: one cycle, fetch_halt=1, no request, then RUN.
- Outputs are combinational from state/inputs. req_fire = imem_req_valid & imem_req_ready.
- Operand priority (RUN/DRAIN):
  - trap_valid: A=trap_vector, B=0, halt=0, flush_if_id=flush_id_ex=1.
  - else ex_redirect_valid: A=ex_redirect_target, B=0, halt=0, both flushes.
  - else replay_req: restore=1, halt=0, flush_if_id=1.
  - else A=pc, B=INSN_BYTES, halt = !req_fire.
- imem_req_valid = (state==RUN) & !stall_id & (outst_cnt < MAX_OUTST) & no redirect/replay this cycle.
- A redirect/replay ignores imem_req_ready and stall_id.
- outst_cnt next = outst_cnt + req_fire - imem_rsp_valid. A simultaneous fire and response leaves it unchanged. It never exceeds MAX_OUTST. A response with outst_cnt==0 is a protocol error: assertion only, counter saturates at 0.
- drop_cnt: on redirect/replay, set to (outst_cnt - imem_rsp_valid), since the same-cycle response is itself dropped. Otherwise it decrements on each imem_rsp_valid while nonzero.
- if_id_valid = imem_rsp_valid & drop_cnt==0 & no redirect/replay this cycle.
- stall_id alone: fetch_halt=1, no new request; in-flight responses still counted.
- RUN -> DRAIN on halt_req: requests stop, redirects still honoured.
- DRAIN -> HALTED when outst_cnt==0 and no response this cycle.
- HALTED: fetch_halt=1, halted=1, redirect/replay/trap ignored. resume_req -> RUN next cycle; PC unchanged.
- Reset mid-operation (any state, counters nonzero) returns to BOOT; responses arriving afterwards are counted from zero.

Decomposition:
- Shared package: fetch_ctrl state encoding (2-bit enum), INSN_BYTES, redirect-source enum (NONE/TRAP/EX/REPLAY) for debug visibility.
- One sub-module, fetch_inflight_tracker: holds outst_cnt/drop_cnt with the inc/dec/load rules and exports can_issue and rsp_stale.

Test Plan:
- Reset then imem_req_ready=1 and 1-cycle responses: BOOT holds PC 0; then requests to 0x0, 0x4, 0x8, if_id_valid each cycle, outst_cnt peaks at 1.
- imem_req_ready low 3 cycles at pc=0x10: fetch_halt=1, no PC change; on ready, fire and B=4 -> pc 0x14.
- Two outstanding (0x20, 0x24), then ex_redirect to 0x100 with no same-cycle response: both flushes, drop_cnt=2. The next two responses give if_id_valid=0. First valid response is for 0x100.
- Simultaneous trap_valid (vector 0x80) and ex_redirect (0x200): PC becomes 0x80; ex target ignored.
- replay_req at pc=0x44, previous 0x40: restore=1, pc returns to 0x40, flush_if_id=1, flush_id_ex=0.
- halt_req with 2 outstanding: DRAIN until both responses return, then HALTED. A redirect in HALTED is ignored. resume_req restarts requests at unchanged PC.
